arith_unit_seq: RTL

Parametrised, digit-serial successor to the 4-bit arithmetic unit. It computes D = A + Beff + C_in, where Beff is selected by a 2-bit mode (B, ~B, 0, all-ones). The datapath is WIDTH bits wide and processes DIGIT bits per clock, reusing one DIGIT-wide adder slice and registering the carry between digits. A valid/ready handshake sits on both the input and the output. The block also produces zero, negative and signed-overflow status flags.

---
 rtl/arith_unit_seq.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/arith_unit_seq.sv
// arith_unit_seq: digit-serial adder computing d = a + beff + c_in.
// beff is chosen by sel (00 b, 01 ~b, 10 zero, 11 all-ones). One DIGIT-wide
// slice is reused for NDIG = WIDTH/DIGIT cycles, LSB digit first, with the
// carry held in a register between digits.
// Optional feature macro: ARITH_FLAGS_EN enables the zero/neg/ovf flags;
// when it is undefined those outputs are tied low.
module arith_unit_seq #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic [1:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             c_out,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_op_q, a_op_d;
  logic [WIDTH-1:0] b_op_q, b_op_d;
  logic [1:0]       sel_op_q, sel_op_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             c_out_q, c_out_d;
  logic             out_valid_q, out_valid_d;
  logic             ready_q, ready_d;

  logic [WIDTH-1:0] beff;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] beff_dig;
  logic [DIGIT:0]   sum;
  logic             last_dig;

  // Effective B operand, taken only from the latched operand registers
  always_comb begin
    beff = b_op_q;
    case (sel_op_q)
      2'b00: beff = b_op_q;
      2'b01: beff = ~b_op_q;
      2'b10: beff = '0;
      2'b11: beff = '1;
      default: beff = b_op_q;
    endcase
  end

  // Select the active digit of each operand and run the shared adder slice
  always_comb begin
    a_dig    = '0;
    beff_dig = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (cnt_q == CW'(k)) begin
        a_dig    = a_op_q[k*DIGIT +: DIGIT];
        beff_dig = beff[k*DIGIT +: DIGIT];
      end
    end
    sum      = {1'b0, a_dig} + {1'b0, beff_dig} + (DIGIT+1)'(carry_q);
    last_dig = (state_q == CALC) && (cnt_q == LAST_DIG);
  end

  // Next-state and datapath updates for the IDLE/CALC/DONE sequence
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_op_d      = a_op_q;
    b_op_d      = b_op_q;
    sel_op_d    = sel_op_q;
    d_d         = d_q;
    c_out_d     = c_out_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid && ready_q) begin
          a_op_d   = a;
          b_op_d   = b;
          sel_op_d = sel;
          carry_d  = c_in;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        for (int k = 0; k < NDIG; k++) begin
          if (cnt_q == CW'(k)) begin
            d_d[k*DIGIT +: DIGIT] = sum[DIGIT-1:0];
          end
        end
        carry_d = sum[DIGIT];
        if (cnt_q == LAST_DIG) begin
          c_out_d     = sum[DIGIT];
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered ready so it stays low through reset and never depends on inputs
    ready_d = (state_d == IDLE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_op_q      <= '0;
      b_op_q      <= '0;
      sel_op_q    <= 2'b00;
      d_q         <= '0;
      c_out_q     <= 1'b0;
      out_valid_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_op_q      <= a_op_d;
      b_op_q      <= b_op_d;
      sel_op_q    <= sel_op_d;
      d_q         <= d_d;
      c_out_q     <= c_out_d;
      out_valid_q <= out_valid_d;
      ready_q     <= ready_d;
    end
  end

`ifdef ARITH_FLAGS_EN
  logic zero_q, zero_d;
  logic neg_q, neg_d;
  logic ovf_q, ovf_d;

  // Status flags evaluated on the final digit; carry into the MSB is
  // recovered from the MSB sum bit as a ^ beff ^ s
  always_comb begin
    zero_d = zero_q;
    neg_d  = neg_q;
    ovf_d  = ovf_q;
    if (last_dig) begin
      zero_d = (d_d == '0);
      neg_d  = d_d[WIDTH-1];
      ovf_d  = (a_dig[DIGIT-1] ^ beff_dig[DIGIT-1] ^ sum[DIGIT-1]) ^ sum[DIGIT];
    end
  end

  // Flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      neg_q  <= neg_d;
      ovf_q  <= ovf_d;
    end
  end

  assign zero = zero_q;
  assign neg  = neg_q;
  assign ovf  = ovf_q;
`else
  assign zero = 1'b0;
  assign neg  = 1'b0;
  assign ovf  = 1'b0;
`endif

  assign in_ready  = ready_q;
  assign out_valid = out_valid_q;
  assign d         = d_q;
  assign c_out     = c_out_q;

endmodule
